// File: rtl/vga_console_pkg.sv
// Shared geometry, control codes and encodings for the VGA console terminal front-end.
package vga_console_pkg;

    localparam int NUM_ROWS  = 3;
    localparam int NUM_COLS  = 10;
    localparam int NUM_CHARS = NUM_ROWS * NUM_COLS;
    localparam int ADDR_W    = 6;
    localparam int ROW_W     = 2;
    localparam int COL_W     = 4;

    localparam logic [2:0] BLANK_COLOR        = 3'b010;
    localparam logic [2:0] DEFAULT_TEXT_COLOR = 3'b111;
    localparam logic [9:0] BLANK_CELL         = {BLANK_COLOR, 7'h20};

    localparam logic [7:0] CC_BS        = 8'h08;
    localparam logic [7:0] CC_LF        = 8'h0A;
    localparam logic [7:0] CC_FF        = 8'h0C;
    localparam logic [7:0] CC_CR        = 8'h0D;
    localparam logic [7:0] PRINT_FIRST  = 8'h20;
    localparam logic [7:0] PRINT_LAST   = 8'h7E;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SCROLL_COPY  = 2'd1,
        SCROLL_CLEAR = 2'd2,
        CLEAR_ALL    = 2'd3
    } tty_state_t;

    typedef enum logic [2:0] {
        CUR_HOLD     = 3'd0,
        CUR_ADVANCE  = 3'd1,
        CUR_HOME     = 3'd2,
        CUR_COL_ZERO = 3'd3,
        CUR_BACK     = 3'd4,
        CUR_NEWLINE  = 3'd5
    } cursor_op_t;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(NUM_COLS) + ADDR_W'(c);
    endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor row/column registers; line breaks on the last row keep the row so the
// caller can scroll the buffer underneath it.
module console_cursor
    import vga_console_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  cursor_op_t       op,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_row,
    output logic             wrap_scroll
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    logic [ROW_W-1:0] row_n;
    logic [COL_W-1:0] col_n;

    assign last_row    = (row == LAST_ROW);
    assign wrap_scroll = last_row && (col == LAST_COL);

    // Next cursor position for the requested operation
    always_comb begin
        row_n = row;
        col_n = col;
        case (op)
            CUR_ADVANCE: begin
                if (col == LAST_COL) begin
                    col_n = '0;
                    row_n = last_row ? row : row + ROW_W'(1);
                end else begin
                    col_n = col + COL_W'(1);
                end
            end
            CUR_NEWLINE: begin
                col_n = '0;
                row_n = last_row ? row : row + ROW_W'(1);
            end
            CUR_HOME: begin
                row_n = '0;
                col_n = '0;
            end
            CUR_COL_ZERO: col_n = '0;
            CUR_BACK: begin
                if (col != '0) begin
                    col_n = col - COL_W'(1);
                end else begin
                    col_n = col;
                end
            end
            default: begin
                row_n = row;
                col_n = col;
            end
        endcase
    end

    // Cursor state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else begin
            row <= row_n;
            col <= col_n;
        end
    end

endmodule

// File: rtl/vga_console_tty.sv
// Terminal front-end: interprets a byte stream into text-buffer writes, with
// scroll-up and full-screen clear sequenced one cell per cycle.
module vga_console_tty
    import vga_console_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        ch_data,
    input  logic [2:0]        ch_color,
    input  logic              ch_valid,
    output logic              ch_ready,
    output logic              tb_we,
    output logic [ADDR_W-1:0] tb_addr,
    output logic [9:0]        tb_wdata,
    output logic [ADDR_W-1:0] tb_raddr,
    input  logic [9:0]        tb_rdata,
    output logic [ROW_W-1:0]  cur_row,
    output logic [COL_W-1:0]  cur_col,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] COPY_LAST  = ADDR_W'(NUM_CHARS - NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(NUM_COLS - 1);
    localparam logic [ADDR_W-1:0] ALL_LAST   = ADDR_W'(NUM_CHARS - 1);
    localparam logic [ADDR_W-1:0] LAST_BASE  = ADDR_W'(NUM_CHARS - NUM_COLS);

    tty_state_t        state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    cursor_op_t        op;
    logic              last_row, wrap_scroll, accept, printable;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [9:0]        wdata_n;

    console_cursor u_cursor (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .row         (cur_row),
        .col         (cur_col),
        .last_row    (last_row),
        .wrap_scroll (wrap_scroll)
    );

    assign ch_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = ch_valid && ch_ready;
    assign printable = (ch_data >= PRINT_FIRST) && (ch_data <= PRINT_LAST);
    // Source row is one row below the destination, so reads always lead writes
    assign tb_raddr  = (state == SCROLL_COPY) ? idx + ADDR_W'(NUM_COLS) : '0;

    // Byte interpretation and scroll/clear sequencing
    always_comb begin
        state_n = state;
        idx_n   = idx;
        op      = CUR_HOLD;
        we_n    = 1'b0;
        addr_n  = tb_addr;
        wdata_n = tb_wdata;
        case (state)
            IDLE: begin
                if (!accept) begin
                    state_n = IDLE;
                end else if (printable) begin
                    we_n    = 1'b1;
                    addr_n  = cell_addr(cur_row, cur_col);
                    wdata_n = {ch_color, ch_data[6:0]};
                    op      = CUR_ADVANCE;
                    if (wrap_scroll) begin
                        state_n = SCROLL_COPY;
                        idx_n   = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    case (ch_data)
                        CC_LF: begin
                            op = CUR_NEWLINE;
                            if (last_row) begin
                                state_n = SCROLL_COPY;
                                idx_n   = '0;
                            end else begin
                                state_n = IDLE;
                            end
                        end
                        CC_CR: op = CUR_COL_ZERO;
                        CC_BS: begin
                            if (cur_col != '0) begin
                                op      = CUR_BACK;
                                we_n    = 1'b1;
                                addr_n  = cell_addr(cur_row, cur_col - COL_W'(1));
                                wdata_n = BLANK_CELL;
                            end else begin
                                op = CUR_HOLD;
                            end
                        end
                        CC_FF: begin
                            op      = CUR_HOME;
                            state_n = CLEAR_ALL;
                            idx_n   = '0;
                        end
                        default: op = CUR_HOLD;
                    endcase
                end
            end
            SCROLL_COPY: begin
                we_n    = 1'b1;
                addr_n  = idx;
                wdata_n = tb_rdata;
                if (idx == COPY_LAST) begin
                    state_n = SCROLL_CLEAR;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + ADDR_W'(1);
                end
            end
            SCROLL_CLEAR: begin
                we_n    = 1'b1;
                addr_n  = LAST_BASE + idx;
                wdata_n = BLANK_CELL;
                if (idx == CLEAR_LAST) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + ADDR_W'(1);
                end
            end
            CLEAR_ALL: begin
                we_n    = 1'b1;
                addr_n  = idx;
                wdata_n = BLANK_CELL;
                if (idx == ALL_LAST) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + ADDR_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    // State, index and registered write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            tb_we    <= 1'b0;
            tb_addr  <= '0;
            tb_wdata <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            tb_we    <= we_n;
            tb_addr  <= addr_n;
            tb_wdata <= wdata_n;
        end
    end

endmodule

// File: tb/tb_vga_console_tty.sv
// Directed self-checking bench for vga_console_tty with a behavioural text buffer.
module tb_vga_console_tty;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ch_data;
    logic [2:0] ch_color;
    logic       ch_valid;
    logic       ch_ready;
    logic       tb_we;
    logic [5:0] tb_addr;
    logic [9:0] tb_wdata;
    logic [5:0] tb_raddr;
    logic [9:0] tb_rdata;
    logic [1:0] cur_row;
    logic [3:0] cur_col;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    logic [9:0] mem [0:29];

    vga_console_tty dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_color(ch_color),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .tb_we(tb_we), .tb_addr(tb_addr),
        .tb_wdata(tb_wdata), .tb_raddr(tb_raddr), .tb_rdata(tb_rdata),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    always #8 clk = ~clk;

    always @(posedge clk) begin
        if (tb_we && tb_addr < 6'd30) mem[tb_addr] <= tb_wdata;
    end
    assign tb_rdata = (tb_raddr < 6'd30) ? mem[tb_raddr] : 10'h000;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [2:0] c);
        int n;
        n = 0;
        ch_data  = b;
        ch_color = c;
        ch_valid = 1'b1;
        while (!ch_ready && n < 100) begin
            tick();
            n++;
        end
        tests++;
        if (!ch_ready) begin
            failed++;
            $display("FAIL send_ready_timeout: got ch_ready=%0b expected 1", ch_ready);
        end
        tick();
        ch_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        tests++;
        if (busy) begin
            failed++;
            $display("FAIL idle_timeout: got busy=%0b expected 0", busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ch_valid = 1'b0; ch_data = 8'h00; ch_color = 3'b000;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_we",     tb_we,    1'b0);
        chk("reset_addr",   tb_addr,  6'd0);
        chk("reset_wdata",  tb_wdata, 10'h000);
        chk("reset_raddr",  tb_raddr, 6'd0);
        chk("reset_busy",   busy,     1'b0);
        chk("reset_ready",  ch_ready, 1'b1);
        chk("reset_cursor", {cur_row, cur_col}, {2'd0, 4'd0});
    endtask

    task automatic test_print_single;
        send(8'h41, 3'b101);
        chk("print_we",     tb_we,    1'b1);
        chk("print_addr",   tb_addr,  6'd0);
        chk("print_wdata",  tb_wdata, 10'h2C1);
        chk("print_cursor", {cur_row, cur_col}, {2'd0, 4'd1});
        tick();
        chk("print_we_drop", tb_we, 1'b0);
    endtask

    task automatic test_row_fill;
        send(8'h0D, 3'b000);
        chk("cr_no_write", tb_we, 1'b0);
        chk("cr_cursor", {cur_row, cur_col}, {2'd0, 4'd0});
        ch_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ch_data  = 8'h30 + 8'(i);
            ch_color = 3'b001;
            tick();
            chk($sformatf("row_write_%0d", i), {tb_we, tb_addr, tb_wdata},
                {1'b1, 6'(i), 3'b001, 7'(8'h30 + i)});
            chk($sformatf("row_ready_%0d", i), ch_ready, 1'b1);
        end
        ch_valid = 1'b0;
        chk("row_cursor", {cur_row, cur_col}, {2'd1, 4'd0});
    endtask

    task automatic test_clear_all;
        send(8'h0C, 3'b000);
        chk("ff_busy", busy, 1'b1);
        chk("ff_no_direct_write", tb_we, 1'b0);
        chk("ff_cursor", {cur_row, cur_col}, {2'd0, 4'd0});
        for (int i = 0; i < 30; i++) begin
            tick();
            chk($sformatf("clear_%0d", i), {tb_we, tb_addr, tb_wdata}, {1'b1, 6'(i), 10'h120});
        end
        chk("clear_done_busy", busy, 1'b0);
        tick();
        chk("clear_done_we", tb_we, 1'b0);
        send(8'h1B, 3'b111);
        chk("esc_no_write", tb_we, 1'b0);
        chk("esc_cursor", {cur_row, cur_col}, {2'd0, 4'd0});
        send(8'h85, 3'b111);
        chk("hi_no_write", tb_we, 1'b0);
        chk("hi_ready", ch_ready, 1'b1);
    endtask

    task automatic test_scroll_fill;
        int n;
        ch_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ch_data  = 8'h21 + 8'(i);
            ch_color = 3'(i);
            tick();
        end
        chk("fill_last_addr", tb_addr, 6'd29);
        chk("fill_busy", busy, 1'b1);
        chk("fill_raddr0", tb_raddr, 6'd10);
        ch_data  = 8'h5A;
        ch_color = 3'b011;
        n = 0;
        while (busy && n < 100) begin
            if (ch_ready !== 1'b0) begin
                tests++; failed++;
                $display("FAIL scroll_ready: got %0b expected 0", ch_ready);
            end
            n++;
            tick();
        end
        chk("scroll_busy_cycles", n, 30);
        chk("scroll_cursor", {cur_row, cur_col}, {2'd2, 4'd0});
        chk("scroll_last_clear", {tb_we, tb_addr, tb_wdata}, {1'b1, 6'd29, 10'h120});
        tick();
        ch_valid = 1'b0;
        chk("held_byte_write", {tb_we, tb_addr, tb_wdata}, {1'b1, 6'd20, 3'b011, 7'h5A});
        chk("held_byte_cursor", {cur_row, cur_col}, {2'd2, 4'd1});
        for (int k = 0; k < 30; k++) begin
            if (k < 20) chk($sformatf("buf_%0d", k), mem[k], {3'(k + 10), 7'(8'h21 + k + 10)});
            else        chk($sformatf("buf_%0d", k), mem[k], 10'h120);
        end
    endtask

    task automatic test_control;
        int n;
        send(8'h0C, 3'b000);
        wait_idle(n);
        send(8'h0A, 3'b000);
        chk("lf_no_write", tb_we, 1'b0);
        chk("lf_cursor", {cur_row, cur_col}, {2'd1, 4'd0});
        repeat (4) send(8'h77, 3'b100);
        chk("pre_bs_cursor", {cur_row, cur_col}, {2'd1, 4'd4});
        send(8'h08, 3'b000);
        chk("bs_write", {tb_we, tb_addr, tb_wdata}, {1'b1, 6'd13, 10'h120});
        chk("bs_cursor", {cur_row, cur_col}, {2'd1, 4'd3});
        send(8'h0D, 3'b000);
        chk("cr2_cursor", {cur_row, cur_col, tb_we}, {2'd1, 4'd0, 1'b0});
        send(8'h08, 3'b000);
        chk("bs_col0", {cur_row, cur_col, tb_we}, {2'd1, 4'd0, 1'b0});
        send(8'h0A, 3'b000);
        chk("lf2_cursor", {cur_row, cur_col, busy}, {2'd2, 4'd0, 1'b0});
        send(8'h0A, 3'b000);
        chk("lf_scroll_busy", busy, 1'b1);
        wait_idle(n);
        chk("lf_scroll_cycles", n, 30);
        chk("lf_scroll_cursor", {cur_row, cur_col}, {2'd2, 4'd0});
        tick();
        chk("lf_buf0",  mem[0],  {3'b100, 7'h77});
        chk("lf_buf2",  mem[2],  {3'b100, 7'h77});
        chk("lf_buf3",  mem[3],  10'h120);
        chk("lf_buf10", mem[10], 10'h120);
        chk("lf_buf20", mem[20], 10'h120);
    endtask

    task automatic test_reset_mid_scroll;
        send(8'h0A, 3'b000);
        repeat (12) tick();
        chk("mid_scroll_we", tb_we, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("abort_we", tb_we, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_cursor", {cur_row, cur_col}, {2'd0, 4'd0});
        rst_n = 1'b1;
        tick();
        chk("abort_ready", ch_ready, 1'b1);
        send(8'h42, 3'b110);
        chk("after_abort_write", {tb_we, tb_addr, tb_wdata}, {1'b1, 6'd0, 10'h342});
    endtask

    initial begin
        test_reset();
        test_print_single();
        test_row_fill();
        test_clear_all();
        test_scroll_fill();
        test_control();
        test_reset_mid_scroll();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
